// File: rtl/alu_pkg.sv
// Shared definitions for the ALU result buffer: opcodes, the per-entry
// layout and the divide-by-zero signature of the upstream 4-bit ALU.
package alu_pkg;

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_DIV = 2'b11;

  // Result value the ALU emits for a division by zero.
  localparam logic [7:0] DZ_RESULT = 8'hFF;

  // Entry layout at the default widths, most significant field first.
  typedef struct packed {
    logic [7:0] result;
    logic [3:0] remainder;
    logic       carry;
    logic       overflow;
    logic [1:0] opcode;
    logic       dz;
  } alu_res_t;

  // The ALU flags a division by zero by raising carry and overflow together
  // on a divide.
  function automatic logic is_dz(input logic [1:0] opcode, input logic carry,
                                 input logic overflow);
    return (opcode == OP_DIV) & carry & overflow;
  endfunction

endpackage

// File: rtl/alu_result_buffer_if.sv
// Bus bundle between the ALU side, the buffer and the consumer.
// master = environment (ALU producer + consumer), slave = the buffer.
// op_count exists only when ALU_RES_STATS_EN is defined.
interface alu_result_buffer_if #(
  parameter int DEPTH = 4,
  parameter int RES_W = 8,
  parameter int REM_W = 4
) ();
  localparam int LVL_W = $clog2(DEPTH) + 1;

  logic             in_valid;
  logic             in_ready;
  logic [RES_W-1:0] in_result;
  logic [REM_W-1:0] in_remainder;
  logic             in_carry;
  logic             in_overflow;
  logic [1:0]       in_opcode;
  logic             out_valid;
  logic             out_ready;
  logic [RES_W-1:0] out_result;
  logic [REM_W-1:0] out_remainder;
  logic             out_carry;
  logic             out_overflow;
  logic [1:0]       out_opcode;
  logic             out_dz;
  logic [LVL_W-1:0] level;
  logic             sticky_carry;
  logic             sticky_ovf;
  logic             sticky_dz;
  logic             clr_sticky;
`ifdef ALU_RES_STATS_EN
  logic [31:0]      op_count;

  modport master (
    output in_valid, in_result, in_remainder, in_carry, in_overflow, in_opcode,
           out_ready, clr_sticky,
    input  in_ready, out_valid, out_result, out_remainder, out_carry,
           out_overflow, out_opcode, out_dz, level, sticky_carry, sticky_ovf,
           sticky_dz, op_count
  );
  modport slave (
    input  in_valid, in_result, in_remainder, in_carry, in_overflow, in_opcode,
           out_ready, clr_sticky,
    output in_ready, out_valid, out_result, out_remainder, out_carry,
           out_overflow, out_opcode, out_dz, level, sticky_carry, sticky_ovf,
           sticky_dz, op_count
  );
`else
  modport master (
    output in_valid, in_result, in_remainder, in_carry, in_overflow, in_opcode,
           out_ready, clr_sticky,
    input  in_ready, out_valid, out_result, out_remainder, out_carry,
           out_overflow, out_opcode, out_dz, level, sticky_carry, sticky_ovf,
           sticky_dz
  );
  modport slave (
    input  in_valid, in_result, in_remainder, in_carry, in_overflow, in_opcode,
           out_ready, clr_sticky,
    output in_ready, out_valid, out_result, out_remainder, out_carry,
           out_overflow, out_opcode, out_dz, level, sticky_carry, sticky_ovf,
           sticky_dz
  );
`endif
endinterface

// File: rtl/sync_fifo.sv
// Generic DEPTH x WIDTH FIFO with occupancy output. Head data is read
// combinationally from the storage array, so a pushed entry shows up one
// cycle later (no fall-through). Ready/valid derive only from the count.
module sync_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_valid,
  output logic                     wr_ready,
  input  logic [WIDTH-1:0]         wr_data,
  output logic                     rd_valid,
  input  logic                     rd_ready,
  output logic [WIDTH-1:0]         rd_data,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;
  localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [LVL_W-1:0] count;
  logic             push;
  logic             pop;

  assign wr_ready = (count != FULL_LVL);
  assign rd_valid = (count != '0);
  assign push     = wr_valid & wr_ready;
  assign pop      = rd_valid & rd_ready;
  assign rd_data  = mem[rd_ptr];
  assign level    = count;

  // Storage write; contents need no reset since count gates visibility.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  // Pointer and occupancy tracking; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + LVL_W'(1);
        2'b01:   count <= count - LVL_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/alu_result_buffer.sv
// ALU result buffer: queues ALU results with their flags, tags
// divide-by-zero per entry, and keeps sticky carry/overflow/dz status.
// Optional per-opcode push counters are built when ALU_RES_STATS_EN is
// defined.
module alu_result_buffer
  import alu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int RES_W = 8,
  parameter int REM_W = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  alu_result_buffer_if.slave bus
);
  localparam int ENTRY_W = RES_W + REM_W + 5;

  logic               in_dz;
  logic               push;
  logic [ENTRY_W-1:0] wr_entry;
  logic [ENTRY_W-1:0] rd_entry;

  assign in_dz    = is_dz(bus.in_opcode, bus.in_carry, bus.in_overflow);
  assign push     = bus.in_valid & bus.in_ready;
  assign wr_entry = {bus.in_result, bus.in_remainder, bus.in_carry,
                     bus.in_overflow, bus.in_opcode, in_dz};

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENTRY_W)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_valid (bus.in_valid),
    .wr_ready (bus.in_ready),
    .wr_data  (wr_entry),
    .rd_valid (bus.out_valid),
    .rd_ready (bus.out_ready),
    .rd_data  (rd_entry),
    .level    (bus.level)
  );

  assign {bus.out_result, bus.out_remainder, bus.out_carry,
          bus.out_overflow, bus.out_opcode, bus.out_dz} = rd_entry;

  // Sticky status: a clear drops old history, but a flag pushed in the same
  // cycle still sets it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bus.sticky_carry <= 1'b0;
      bus.sticky_ovf   <= 1'b0;
      bus.sticky_dz    <= 1'b0;
    end else begin
      bus.sticky_carry <= (bus.sticky_carry & ~bus.clr_sticky) | (push & bus.in_carry);
      bus.sticky_ovf   <= (bus.sticky_ovf & ~bus.clr_sticky) | (push & bus.in_overflow);
      bus.sticky_dz    <= (bus.sticky_dz & ~bus.clr_sticky) | (push & in_dz);
    end
  end

`ifdef ALU_RES_STATS_EN
  // One saturating 8-bit counter per opcode, packed add/sub/mul/div from LSB.
  for (genvar gi = 0; gi < 4; gi++) begin : g_stat
    logic [7:0] cnt;
    logic       inc;

    assign inc = push & (bus.in_opcode == 2'(gi));
    assign bus.op_count[gi*8 +: 8] = cnt;

    // Clear restarts the count; a coinciding push counts as the first.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)               cnt <= 8'h00;
      else if (bus.clr_sticky)  cnt <= {7'b0, inc};
      else if (inc && cnt != 8'hFF) cnt <= cnt + 8'h01;
    end
  end
`endif

endmodule

// File: tb/tb_alu_result_buffer.sv
// Directed bench for alu_result_buffer: a vector table for the handshake,
// ordering, dz and sticky behaviour, plus hand-written async-reset and
// (with ALU_RES_STATS_EN) counter saturation sequences.
module tb_alu_result_buffer;
  import alu_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   failures = 0;

  always #5 clk = ~clk;

  alu_result_buffer_if #(.DEPTH(4), .RES_W(8), .REM_W(4)) bus ();

  alu_result_buffer #(.DEPTH(4), .RES_W(8), .REM_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic       iv;
    logic [7:0] res;
    logic [3:0] rem;
    logic       c;
    logic       o;
    logic [1:0] op;
    logic       ordy;
    logic       clr;
    logic       e_ov;
    logic [2:0] e_lvl;
    logic       e_ir;
    logic [7:0] e_res;
    logic [3:0] e_rem;
    logic [1:0] e_op;
    logic       e_c;
    logic       e_o;
    logic       e_dz;
    logic [2:0] e_st;   // {sticky_carry, sticky_ovf, sticky_dz}
  } vec_t;

  vec_t vecs [26];

  function automatic vec_t mk(
      logic iv, logic [7:0] res, logic [3:0] rem, logic c, logic o,
      logic [1:0] op, logic ordy, logic clr,
      logic e_ov, logic [2:0] e_lvl, logic e_ir, logic [7:0] e_res,
      logic [3:0] e_rem, logic [1:0] e_op, logic e_c, logic e_o, logic e_dz,
      logic [2:0] e_st);
    vec_t v;
    v.iv = iv; v.res = res; v.rem = rem; v.c = c; v.o = o; v.op = op;
    v.ordy = ordy; v.clr = clr; v.e_ov = e_ov; v.e_lvl = e_lvl; v.e_ir = e_ir;
    v.e_res = e_res; v.e_rem = e_rem; v.e_op = e_op; v.e_c = e_c; v.e_o = e_o;
    v.e_dz = e_dz; v.e_st = e_st;
    return v;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic drive(input logic iv, input logic [7:0] res, input logic [3:0] rem,
                       input logic c, input logic o, input logic [1:0] op,
                       input logic ordy, input logic clr);
    bus.in_valid = iv; bus.in_result = res; bus.in_remainder = rem;
    bus.in_carry = c; bus.in_overflow = o; bus.in_opcode = op;
    bus.out_ready = ordy; bus.clr_sticky = clr;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_level"}, 32'(bus.level), 32'd0);
    chk({tag, "_out_valid"}, 32'(bus.out_valid), 32'd0);
    chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
    chk({tag, "_sticky"}, 32'({bus.sticky_carry, bus.sticky_ovf, bus.sticky_dz}), 32'd0);
  endtask

  initial begin
    //        iv res   rem c o op   rdy clr | ov lvl ir res   rem op c o dz st
    vecs[0]  = mk(1, 8'h0C, 4'h0, 0, 0, 2'd0, 0, 0,  1, 3'd1, 1, 8'h0C, 4'h0, 2'd0, 0, 0, 0, 3'b000);
    vecs[1]  = mk(0, 8'h00, 4'h0, 0, 0, 2'd0, 1, 0,  0, 3'd0, 1, 8'h00, 4'h0, 2'd0, 0, 0, 0, 3'b000);
    vecs[2]  = mk(1, 8'h01, 4'h1, 0, 0, 2'd1, 0, 0,  1, 3'd1, 1, 8'h01, 4'h1, 2'd1, 0, 0, 0, 3'b000);
    vecs[3]  = mk(1, 8'h02, 4'h2, 0, 0, 2'd2, 0, 0,  1, 3'd2, 1, 8'h01, 4'h1, 2'd1, 0, 0, 0, 3'b000);
    vecs[4]  = mk(1, 8'h03, 4'h3, 0, 0, 2'd0, 0, 0,  1, 3'd3, 1, 8'h01, 4'h1, 2'd1, 0, 0, 0, 3'b000);
    vecs[5]  = mk(1, 8'h04, 4'h4, 0, 0, 2'd1, 0, 0,  1, 3'd4, 0, 8'h01, 4'h1, 2'd1, 0, 0, 0, 3'b000);
    vecs[6]  = mk(1, 8'h05, 4'h5, 1, 1, 2'd3, 0, 0,  1, 3'd4, 0, 8'h01, 4'h1, 2'd1, 0, 0, 0, 3'b000);
    vecs[7]  = mk(0, 8'h00, 4'h0, 0, 0, 2'd0, 1, 0,  1, 3'd3, 1, 8'h02, 4'h2, 2'd2, 0, 0, 0, 3'b000);
    vecs[8]  = mk(0, 8'h00, 4'h0, 0, 0, 2'd0, 1, 0,  1, 3'd2, 1, 8'h03, 4'h3, 2'd0, 0, 0, 0, 3'b000);
    vecs[9]  = mk(0, 8'h00, 4'h0, 0, 0, 2'd0, 1, 0,  1, 3'd1, 1, 8'h04, 4'h4, 2'd1, 0, 0, 0, 3'b000);
    vecs[10] = mk(0, 8'h00, 4'h0, 0, 0, 2'd0, 1, 0,  0, 3'd0, 1, 8'h00, 4'h0, 2'd0, 0, 0, 0, 3'b000);
    vecs[11] = mk(1, 8'h10, 4'h0, 0, 0, 2'd0, 0, 0,  1, 3'd1, 1, 8'h10, 4'h0, 2'd0, 0, 0, 0, 3'b000);
    vecs[12] = mk(1, 8'h11, 4'h1, 0, 0, 2'd2, 0, 0,  1, 3'd2, 1, 8'h10, 4'h0, 2'd0, 0, 0, 0, 3'b000);
    vecs[13] = mk(1, 8'h12, 4'h2, 0, 0, 2'd0, 1, 0,  1, 3'd2, 1, 8'h11, 4'h1, 2'd2, 0, 0, 0, 3'b000);
    vecs[14] = mk(1, 8'h13, 4'h3, 0, 0, 2'd0, 1, 0,  1, 3'd2, 1, 8'h12, 4'h2, 2'd0, 0, 0, 0, 3'b000);
    vecs[15] = mk(1, 8'h14, 4'h4, 0, 0, 2'd0, 1, 0,  1, 3'd2, 1, 8'h13, 4'h3, 2'd0, 0, 0, 0, 3'b000);
    vecs[16] = mk(1, 8'h15, 4'h5, 0, 0, 2'd0, 1, 0,  1, 3'd2, 1, 8'h14, 4'h4, 2'd0, 0, 0, 0, 3'b000);
    vecs[17] = mk(1, 8'h16, 4'h6, 0, 0, 2'd0, 1, 0,  1, 3'd2, 1, 8'h15, 4'h5, 2'd0, 0, 0, 0, 3'b000);
    vecs[18] = mk(1, 8'h17, 4'h7, 0, 0, 2'd0, 1, 0,  1, 3'd2, 1, 8'h16, 4'h6, 2'd0, 0, 0, 0, 3'b000);
    vecs[19] = mk(0, 8'h00, 4'h0, 0, 0, 2'd0, 1, 0,  1, 3'd1, 1, 8'h17, 4'h7, 2'd0, 0, 0, 0, 3'b000);
    vecs[20] = mk(0, 8'h00, 4'h0, 0, 0, 2'd0, 1, 0,  0, 3'd0, 1, 8'h00, 4'h0, 2'd0, 0, 0, 0, 3'b000);
    vecs[21] = mk(1, 8'hFF, 4'hF, 1, 1, 2'd3, 0, 0,  1, 3'd1, 1, 8'hFF, 4'hF, 2'd3, 1, 1, 1, 3'b111);
    vecs[22] = mk(1, 8'h03, 4'h1, 0, 0, 2'd3, 1, 0,  1, 3'd1, 1, 8'h03, 4'h1, 2'd3, 0, 0, 0, 3'b111);
    vecs[23] = mk(0, 8'h00, 4'h0, 0, 0, 2'd0, 1, 1,  0, 3'd0, 1, 8'h00, 4'h0, 2'd0, 0, 0, 0, 3'b000);
    vecs[24] = mk(1, 8'h09, 4'h0, 1, 0, 2'd0, 0, 1,  1, 3'd1, 1, 8'h09, 4'h0, 2'd0, 1, 0, 0, 3'b100);
    vecs[25] = mk(0, 8'h00, 4'h0, 0, 0, 2'd0, 1, 1,  0, 3'd0, 1, 8'h00, 4'h0, 2'd0, 0, 0, 0, 3'b000);

    drive(0, 8'h00, 4'h0, 0, 0, 2'd0, 0, 0);

    // Reset state, held across a couple of edges.
    #2;
    chk_idle("reset_async");
    step();
    step();
    chk_idle("reset_held");
    #2 rst_n = 1'b1;
    step();
    chk_idle("after_release");
    $display("txn reset: level=%0d out_valid=%0b in_ready=%0b", bus.level, bus.out_valid, bus.in_ready);

    // Vector table.
    for (int i = 0; i < 26; i++) begin
      drive(vecs[i].iv, vecs[i].res, vecs[i].rem, vecs[i].c, vecs[i].o,
            vecs[i].op, vecs[i].ordy, vecs[i].clr);
      step();
      $display("txn v%0d: iv=%0b res=%02h op=%0d rdy=%0b clr=%0b -> ov=%0b lvl=%0d head=%02h dz=%0b st=%0b%0b%0b",
               i, vecs[i].iv, vecs[i].res, vecs[i].op, vecs[i].ordy, vecs[i].clr,
               bus.out_valid, bus.level, bus.out_result, bus.out_dz,
               bus.sticky_carry, bus.sticky_ovf, bus.sticky_dz);
      chk($sformatf("v%0d_out_valid", i), 32'(bus.out_valid), 32'(vecs[i].e_ov));
      chk($sformatf("v%0d_level", i), 32'(bus.level), 32'(vecs[i].e_lvl));
      chk($sformatf("v%0d_in_ready", i), 32'(bus.in_ready), 32'(vecs[i].e_ir));
      chk($sformatf("v%0d_sticky", i),
          32'({bus.sticky_carry, bus.sticky_ovf, bus.sticky_dz}), 32'(vecs[i].e_st));
      if (vecs[i].e_ov) begin
        chk($sformatf("v%0d_head", i),
            32'({bus.out_result, bus.out_remainder, bus.out_opcode,
                 bus.out_carry, bus.out_overflow, bus.out_dz}),
            32'({vecs[i].e_res, vecs[i].e_rem, vecs[i].e_op,
                 vecs[i].e_c, vecs[i].e_o, vecs[i].e_dz}));
      end
    end

    // Head stays stable while stalled: push one, hold out_ready low.
    drive(1, 8'hA5, 4'h6, 0, 0, 2'd2, 0, 0);
    step();
    drive(0, 8'h00, 4'h0, 0, 0, 2'd0, 0, 0);
    step();
    step();
    chk("stall_head", 32'({bus.out_valid, bus.out_result, bus.out_remainder}), 32'h1_A5_6);
    $display("txn stall: head=%02h level=%0d", bus.out_result, bus.level);

    // Async reset mid-cycle with three entries queued and sticky_ovf set.
    drive(1, 8'h21, 4'h0, 0, 1, 2'd1, 0, 0);
    step();
    drive(1, 8'h22, 4'h0, 0, 0, 2'd1, 0, 0);
    step();
    drive(0, 8'h00, 4'h0, 0, 0, 2'd0, 0, 0);
    chk("pre_reset_level", 32'(bus.level), 32'd3);
    chk("pre_reset_ovf", 32'(bus.sticky_ovf), 32'd1);
    #3 rst_n = 1'b0;
    #1;
    chk_idle("midcycle_reset");
    $display("txn async_reset: level=%0d out_valid=%0b", bus.level, bus.out_valid);
    #2 rst_n = 1'b1;
    drive(1, 8'h33, 4'h3, 0, 0, 2'd0, 0, 0);
    step();
    drive(0, 8'h00, 4'h0, 0, 0, 2'd0, 0, 0);
    chk("post_reset_push", 32'({bus.level, bus.out_result}), 32'({3'd1, 8'h33}));

`ifdef ALU_RES_STATS_EN
    // Stats: counts since the reset above are add=1 so far.
    chk("stats_after_reset", bus.op_count, 32'h0000_0001);
    drive(1, 8'h01, 4'h0, 0, 0, 2'd0, 1, 1);
    step();
    chk("stats_clr_and_inc", bus.op_count, 32'h0000_0001);
    for (int n = 0; n < 300; n++) begin
      drive(1, 8'h01, 4'h0, 0, 0, OP_ADD, 1, 0);
      step();
    end
    drive(1, 8'h02, 4'h0, 0, 0, OP_MUL, 1, 0);
    step();
    drive(0, 8'h00, 4'h0, 0, 0, 2'd0, 1, 0);
    step();
    chk("stats_add_saturate", bus.op_count, 32'h0001_00FF);
    $display("txn stats: op_count=%08h", bus.op_count);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
